// File: rtl/pixel_block_fetch_pkg.sv
// Shared FSM state, segment encoding and frame-layout constants for the 8x8 block fetcher.
package pixel_block_fetch_pkg;

    typedef enum logic [2:0] {IDLE, LI_0, LI_1, ROW, LO_0, LO_1, DONE} state_e;
    typedef enum logic [1:0] {SEG_Y, SEG_U, SEG_V} seg_e;

    localparam logic [17:0] Y_BASE   = 18'd0;
    localparam logic [17:0] U_BASE   = 18'd38400;
    localparam logic [17:0] V_BASE   = 18'd57600;
    localparam logic [17:0] Y_PITCH  = 18'd160;
    localparam logic [17:0] UV_PITCH = 18'd80;

    localparam logic [11:0] Y_BLOCKS     = 12'd1200;
    localparam logic [11:0] UV_BLOCKS    = 12'd600;
    localparam logic [11:0] TOTAL_BLOCKS = Y_BLOCKS + UV_BLOCKS + UV_BLOCKS;

    localparam logic [4:0] BLOCK_ROWS    = 5'd30;
    localparam logic [5:0] Y_BLOCK_COLS  = 6'd40;
    localparam logic [5:0] UV_BLOCK_COLS = 6'd20;

    function automatic logic [17:0] seg_base(input seg_e seg);
        case (seg)
            SEG_U:   return U_BASE;
            SEG_V:   return V_BASE;
            default: return Y_BASE;
        endcase
    endfunction

    function automatic logic [17:0] seg_pitch(input seg_e seg);
        return (seg == SEG_Y) ? Y_PITCH : UV_PITCH;
    endfunction

    function automatic logic [5:0] seg_cols(input seg_e seg);
        return (seg == SEG_Y) ? Y_BLOCK_COLS : UV_BLOCK_COLS;
    endfunction

    function automatic seg_e next_seg(input seg_e seg);
        case (seg)
            SEG_Y:   return SEG_U;
            SEG_U:   return SEG_V;
            default: return SEG_Y;
        endcase
    endfunction

endpackage

// File: rtl/pixel_block_fetch_address_gen.sv
// Combinational SRAM word address for word (j,i) of block (r,c) in a plane segment.
module block_address_gen
    import pixel_block_fetch_pkg::*;
(
    input  seg_e        seg,
    input  logic [4:0]  r,
    input  logic [5:0]  c,
    input  logic [2:0]  j,
    input  logic [1:0]  i,
    output logic [17:0] addr
);

    logic [17:0] pitch;
    logic [17:0] line;

    always_comb begin
        pitch = seg_pitch(seg);
        // Pixel line inside the plane: r*8 + j, scaled by the plane pitch.
        line  = {10'd0, r, 3'd0} + {15'd0, j};
        addr  = seg_base(seg) + line * pitch + {10'd0, c, 2'd0} + {16'd0, i};
    end

endmodule

// File: rtl/pixel_block_fetch.sv
// Streams one 8x8 pixel block per Start from packed SRAM into byte-per-word DPRAM, Y then U then V.
module pixel_block_fetch
    import pixel_block_fetch_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Last_block,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic [6:0]  DP_address_a,
    output logic [6:0]  DP_address_b,
    output logic [31:0] DP_write_data_a,
    output logic [31:0] DP_write_data_b,
    output logic        DP_wren_a,
    output logic        DP_wren_b
);

    state_e      state, state_next;
    logic [11:0] block_cnt;
    seg_e        seg;
    logic [4:0]  blk_r;
    logic [5:0]  blk_c;

    // Next word to issue; bit 5 set means all 32 words of the block are issued.
    logic [5:0]  issue_idx;
    logic        issue;
    logic [17:0] word_addr;

    logic        vld_p0, vld_p1, vld_p2;
    logic [4:0]  idx_p0, idx_p1, idx_p2;

    block_address_gen u_addr (
        .seg  (seg),
        .r    (blk_r),
        .c    (blk_c),
        .j    (issue_idx[4:2]),
        .i    (issue_idx[1:0]),
        .addr (word_addr)
    );

    assign issue      = (state == IDLE) ? Start : !issue_idx[5];
    assign Busy       = (state != IDLE);
    assign Done       = (state == DONE);
    assign Last_block = (state == DONE) && (block_cnt == TOTAL_BLOCKS - 12'd1);
    assign SRAM_we_n  = 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = LI_0;
            LI_0:    state_next = LI_1;
            LI_1:    state_next = ROW;
            ROW:     if (vld_p1 && idx_p1 == 5'd31) state_next = LO_0;
            LO_0:    state_next = LO_1;
            LO_1:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            block_cnt       <= '0;
            seg             <= SEG_Y;
            blk_r           <= '0;
            blk_c           <= '0;
            issue_idx       <= '0;
            SRAM_address    <= '0;
            vld_p0          <= 1'b0;
            vld_p1          <= 1'b0;
            vld_p2          <= 1'b0;
            idx_p0          <= '0;
            idx_p1          <= '0;
            idx_p2          <= '0;
            DP_address_a    <= '0;
            DP_address_b    <= '0;
            DP_write_data_a <= '0;
            DP_write_data_b <= '0;
            DP_wren_a       <= 1'b0;
            DP_wren_b       <= 1'b0;
        end else begin
            state <= state_next;

            // p0: address issue to SRAM
            vld_p0 <= issue;
            if (issue) begin
                SRAM_address <= word_addr;
                idx_p0       <= issue_idx[4:0];
                issue_idx    <= issue_idx + 6'd1;
            end

            // p1/p2: wait out the two-cycle SRAM read latency
            vld_p1 <= vld_p0;
            idx_p1 <= idx_p0;
            vld_p2 <= vld_p1;
            idx_p2 <= idx_p1;

            // p2 -> DPRAM: split the pixel pair, even column on port a
            DP_wren_a <= vld_p2;
            DP_wren_b <= vld_p2;
            if (vld_p2) begin
                DP_address_a    <= {1'b0, idx_p2, 1'b0};
                DP_address_b    <= {1'b0, idx_p2, 1'b1};
                DP_write_data_a <= {24'd0, SRAM_read_data[15:8]};
                DP_write_data_b <= {24'd0, SRAM_read_data[7:0]};
            end

            if (state == DONE) begin
                issue_idx <= '0;
                block_cnt <= (block_cnt == TOTAL_BLOCKS - 12'd1) ? 12'd0 : block_cnt + 12'd1;
                if (blk_c == seg_cols(seg) - 6'd1) begin
                    blk_c <= '0;
                    if (blk_r == BLOCK_ROWS - 5'd1) begin
                        blk_r <= '0;
                        seg   <= next_seg(seg);
                    end else begin
                        blk_r <= blk_r + 5'd1;
                    end
                end else begin
                    blk_c <= blk_c + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_block_fetch.sv
// Scoreboard bench for pixel_block_fetch: SRAM model with 2-cycle latency, expected addresses and DPRAM writes queued per fetch.
module tb_pixel_block_fetch;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Busy, Done, Last_block;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic        SRAM_we_n;
    logic [6:0]  DP_address_a, DP_address_b;
    logic [31:0] DP_write_data_a, DP_write_data_b;
    logic        DP_wren_a, DP_wren_b;

    typedef struct packed {
        logic [6:0]  aa;
        logic [31:0] da;
        logic [6:0]  ab;
        logic [31:0] db;
    } dp_t;

    logic [17:0] addr_q[$];
    dp_t         dp_q[$];

    int          errors = 0;
    int          checks = 0;
    logic [17:0] first_addr, row2_addr;
    logic        last_seen;
    int          done_cnt;
    logic [17:0] addr_d1, addr_d2;

    pixel_block_fetch dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Start           (Start),
        .Busy            (Busy),
        .Done            (Done),
        .Last_block      (Last_block),
        .SRAM_address    (SRAM_address),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_we_n       (SRAM_we_n),
        .DP_address_a    (DP_address_a),
        .DP_address_b    (DP_address_b),
        .DP_write_data_a (DP_write_data_a),
        .DP_write_data_b (DP_write_data_b),
        .DP_wren_a       (DP_wren_a),
        .DP_wren_b       (DP_wren_b)
    );

    always #5 Clock = ~Clock;

    // Expected address of word (j,i) of global block number blk.
    function automatic logic [17:0] exp_word_addr(input int blk, input int j, input int i);
        int base, pitch, cols, idx, r, c;
        if (blk < 1200) begin
            base = 0; pitch = 160; cols = 40; idx = blk;
        end else if (blk < 1800) begin
            base = 38400; pitch = 80; cols = 20; idx = blk - 1200;
        end else begin
            base = 57600; pitch = 80; cols = 20; idx = blk - 1800;
        end
        r = idx / cols;
        c = idx % cols;
        return 18'(base + r * 8 * pitch + c * 4 + j * pitch + i);
    endfunction

    // SRAM contents: word k of a block holds {2k,2k+1}, XORed with upper address bits (zero inside Y block 0).
    function automatic logic [15:0] sram_word(input logic [17:0] a);
        int ai, off, pitch, j, i, k;
        logic [7:0] salt;
        ai = int'(a);
        if (ai < 38400) begin
            off = 0; pitch = 160;
        end else if (ai < 57600) begin
            off = 38400; pitch = 80;
        end else begin
            off = 57600; pitch = 80;
        end
        j = ((ai - off) / pitch) % 8;
        i = (ai - off) % 4;
        k = j * 4 + i;
        salt = {1'b0, a[17:11]};
        return {8'(2 * k) ^ salt, 8'(2 * k + 1) ^ salt};
    endfunction

    always @(posedge Clock) begin
        addr_d1 <= SRAM_address;
        addr_d2 <= addr_d1;
    end

    always_comb SRAM_read_data = sram_word(addr_d2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_block(input int blk);
        logic [17:0] a;
        logic [15:0] w;
        dp_t e;
        for (int k = 0; k < 32; k++) begin
            a = exp_word_addr(blk, k / 4, k % 4);
            addr_q.push_back(a);
            w = sram_word(a);
            e.aa = 7'(2 * k);
            e.da = {24'd0, w[15:8]};
            e.ab = 7'(2 * k + 1);
            e.db = {24'd0, w[7:0]};
            dp_q.push_back(e);
        end
    endtask

    // Fully checked fetch; pulse_a/pulse_b are cycles in which an extra Start is driven.
    task automatic run_fetch(input int blk, input int pulse_a, input int pulse_b);
        logic [17:0] a;
        dp_t e;
        push_block(blk);
        done_cnt  = 0;
        last_seen = 1'b0;
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        for (int cyc = 1; cyc <= 37; cyc++) begin
            @(negedge Clock);
            check("busy", Busy, cyc <= 36);
            check("done", Done, cyc == 36);
            check("we_n", SRAM_we_n, 1);
            check("wren_a", DP_wren_a, cyc >= 4 && cyc <= 35);
            check("wren_b", DP_wren_b, cyc >= 4 && cyc <= 35);
            if (Done) begin
                done_cnt++;
                last_seen = Last_block;
                check("last_block", Last_block, blk == 2399);
            end
            if (cyc <= 32 && addr_q.size() > 0) begin
                a = addr_q.pop_front();
                check("sram_addr", SRAM_address, a);
                if (cyc == 1) first_addr = SRAM_address;
                if (cyc == 5) row2_addr = SRAM_address;
            end
            if (DP_wren_a) begin
                if (dp_q.size() == 0) begin
                    check("dp_q_underflow", DP_wren_a, 0);
                end else begin
                    e = dp_q.pop_front();
                    check("dp_addr_a", DP_address_a, e.aa);
                    check("dp_data_a", DP_write_data_a, e.da);
                    check("dp_addr_b", DP_address_b, e.ab);
                    check("dp_data_b", DP_write_data_b, e.db);
                end
            end
            Start = (cyc == pulse_a || cyc == pulse_b);
        end
        Start = 1'b0;
        check("addr_q_left", addr_q.size(), 0);
        check("dp_q_left", dp_q.size(), 0);
    endtask

    // Lightly checked fetch used to walk the block counter forward.
    task automatic fast_fetch(input int blk);
        logic got;
        got = 1'b0;
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge Clock);
            if (cyc == 1) check("fast_base", SRAM_address, exp_word_addr(blk, 0, 0));
            if (Done) begin
                got = 1'b1;
                check("fast_last", Last_block, blk == 2399);
                break;
            end
        end
        check("fast_done", got, 1);
        @(negedge Clock);
    endtask

    task automatic abort_fetch(input int blk, input int at);
        logic [17:0] a;
        push_block(blk);
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        for (int cyc = 1; cyc < at; cyc++) begin
            @(negedge Clock);
            a = addr_q.pop_front();
            check("abort_addr", SRAM_address, a);
        end
        @(negedge Clock);
        check("pre_abort_wren", DP_wren_a, 1);
        Reset = 1'b1;
        #1;
        check("abort_wren_a", DP_wren_a, 0);
        check("abort_wren_b", DP_wren_b, 0);
        check("abort_busy", Busy, 0);
        check("abort_addr0", SRAM_address, 0);
        addr_q.delete();
        dp_q.delete();
        @(negedge Clock);
        Reset = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clock);
            check("post_abort_done", Done, 0);
            check("post_abort_wren", DP_wren_a, 0);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_last", Last_block, 0);
        check("rst_addr", SRAM_address, 0);
        check("rst_we_n", SRAM_we_n, 1);
        check("rst_dp_addr_a", DP_address_a, 0);
        check("rst_dp_addr_b", DP_address_b, 0);
        check("rst_dp_data_a", DP_write_data_a, 0);
        check("rst_dp_data_b", DP_write_data_b, 0);
        check("rst_wren_a", DP_wren_a, 0);
        check("rst_wren_b", DP_wren_b, 0);
        Reset = 1'b0;

        run_fetch(0, 0, 0);
        check("s1_base", first_addr, 18'd0);
        check("s1_row2", row2_addr, 18'd160);
        check("s1_last", last_seen, 0);

        for (int b = 1; b < 40; b++) fast_fetch(b);
        run_fetch(40, 0, 0);
        check("s2_base", first_addr, 18'd1280);

        for (int b = 41; b < 1200; b++) fast_fetch(b);
        run_fetch(1200, 0, 0);
        check("s3_base", first_addr, 18'd38400);
        check("s3_row2", row2_addr, 18'd38480);

        for (int b = 1201; b < 2399; b++) fast_fetch(b);
        run_fetch(2399, 0, 0);
        check("s4_base", first_addr, 18'd76236);
        check("s4_last", last_seen, 1);
        run_fetch(0, 0, 0);
        check("s4_wrap_base", first_addr, 18'd0);

        run_fetch(1, 5, 36);
        check("s5_one_done", done_cnt, 1);
        run_fetch(2, 0, 0);
        check("s5_next_base", first_addr, 18'd8);

        abort_fetch(3, 20);
        run_fetch(0, 0, 0);
        check("s6_restart_base", first_addr, 18'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_block_fetch.md
PIXEL_BLOCK_FETCH -- requirements
Module: pixel_block_fetch

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request to fetch the next 8x8 block.
- Busy  out  1  high while a fetch is in progress.
- Done  out  1  one-cycle pulse when the block is fully written to DPRAM.
- Last_block  out  1  high with Done when the fetched block is V block 599.
- SRAM_address  out  18  SRAM word address.
- SRAM_read_data  in  16  packed pixel pair, [15:8] even column, [7:0] odd column.
- SRAM_we_n  out  1  SRAM write enable, active-low.
- DP_address_a / DP_address_b  out  7  DPRAM port addresses.
- DP_write_data_a / DP_write_data_b  out  32  DPRAM write data.
- DP_wren_a / DP_wren_b  out  1  DPRAM write enables.

Function
REQ-002 SHALL hold SRAM_we_n at 1 in every cycle, because this block only reads SRAM.
REQ-003 SHALL fetch blocks in a fixed order:
- Y blocks 0..1199: 30 block-rows x 40 block-cols, base 0, row pitch 160 words.
- then U blocks 0..599: 30 x 20, base 38400, pitch 80.
- then V blocks 0..599: 30 x 20, base 57600, pitch 80.
REQ-004 Block base address SHALL be seg_base + r*8*pitch + c*4; word (row j 0..7, col i 0..3) SHALL be at base + j*pitch + i.
REQ-005 SHALL have FSM states IDLE, LI_0, LI_1, ROW, LO_0, LO_1, DONE:
- IDLE -> LI_0 on Start.
- LI_0 -> LI_1 -> ROW.
- ROW stays in ROW until all 32 addresses are issued, then -> LO_0 -> LO_1 -> DONE.
- DONE -> IDLE.
REQ-006 With Start sampled high at edge 0, SHALL drive the 32 word addresses in order (j-major, then i) during cycles 1..32.
REQ-007 SRAM read latency SHALL be 2 cycles: data for the address driven in cycle k is valid in cycle k+2.
REQ-008 Data valid in cycle k+2 SHALL be presented, registered, to DPRAM in cycle k+3:
- Port a: address j*8+2i, data {24'd0, word[15:8]}.
- Port b: address j*8+2i+1, data {24'd0, word[7:0]}.
- DP_wren_a and DP_wren_b both high.
REQ-009 DP_wren_a/b SHALL be high only in cycles 4..35; they SHALL be low in all other cycles.
REQ-010 Done SHALL pulse in cycle 36. Busy SHALL be high in cycles 1..36.
REQ-011 Start while Busy is high SHALL be ignored, with no queuing.
REQ-012 After the fetch of V block 599, the block counter SHALL wrap to Y block 0.
REQ-013 Block counter SHALL advance exactly once per fetch, in the DONE state.
REQ-014 Start asserted in the same cycle as Done SHALL be ignored. The next fetch SHALL be accepted from IDLE.
REQ-015 Block counter arithmetic SHALL be unsigned 12-bit (0..2399). Address arithmetic SHALL be 18-bit unsigned with no truncation.

Reset
REQ-016 Reset SHALL force, asynchronously:
- FSM to IDLE and block counter to 0 (Y, r=0, c=0).
- SRAM_address=0, SRAM_we_n=1.
- DP addresses=0, write data=0, DP_wren_a/b=0.
- Busy=0, Done=0, Last_block=0.
REQ-017 Reset during a fetch SHALL abort the fetch, produce no further DPRAM writes and no Done, and restart the sequence at Y block 0.

Structure
REQ-018 The FSM state enum and the constants 0/38400/57600, 160/80 pitches and block counts 1200/600 SHALL reside in the shared state/define package.
REQ-019 Address computation SHALL be one sub-module, block_address_gen (inputs: segment, r, c, j, i; output: 18-bit address), purely combinational.
REQ-020 The 8-bit-to-32-bit zero-extension SHALL stay in pixel_block_fetch.

Verification
REQ-021 Scenario 1: After reset, Start once; SRAM word k holds 16'h{2k,2k+1}.
- Addresses 0,1,2,3,160,...,1123 in cycles 1..32.
- DPRAM[n] = n for n=0..63.
- Done in cycle 36; Last_block=0.
REQ-022 Scenario 2: Fetch 41 blocks; 41st block base address = 1280 (r=1, c=0).
REQ-023 Scenario 3: Fetch block 1200; base = 38400; second row address = 38480.
REQ-024 Scenario 4: Fetch block 2399.
- Base = 57600 + 29*640 + 19*4 = 76236.
- Last_block=1 with Done.
- Next fetch base = 0.
REQ-025 Scenario 5: Start pulsed at cycles 5 and 36 of an active fetch -> both ignored; exactly one Done; counter +1.
REQ-026 Scenario 6: Reset asserted at cycle 20 -> wren low immediately, no Done; next Start fetches from address 0.
